sram_port_arbiter: RTL

Shares one synchronous single-port SRAM (1-cycle read latency) between the fetch stage and the memory stage. Each side uses a split request/response handshake. `addr_ok` accepts a request, and `data_ok` returns the read data or write acknowledge exactly one cycle later. The arbiter grants at most one request per cycle and tracks which requester owns the in-flight response. Fetch sits on the inst port and the memory stage on the data port. The SRAM macro is the only downstream device.

---
 rtl/sram_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one pipelined single-port SRAM (1-cycle read latency) between the
// fetch (inst) port and the memory-stage (data) port. At most one request is
// granted per cycle. The response returns exactly one cycle after its grant.
// Optional build macro: SRAM_ARB_RR_EN selects round-robin arbitration on
// contention. Without it, the data port always wins.
module sram_port_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_grant_any;
    logic        w_data_write;
    logic        r_resp_vld;
    logic        r_resp_owner;   // 0 = inst, 1 = data
    logic [31:0] r_inst_hold;
    logic [31:0] r_data_hold;

`ifdef SRAM_ARB_RR_EN
    logic        r_last_grant;   // 0 = inst won last, 1 = data won last

    // Round-robin arbitration: on contention, the side that did not win last goes
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (resetn) begin
            if (inst_req && data_req) begin
                w_grant_inst = r_last_grant;
                w_grant_data = ~r_last_grant;
            end else begin
                w_grant_inst = inst_req;
                w_grant_data = data_req;
            end
        end
    end

    // Remember the winner of every grant; reset favours fetch on first contention
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_data;
        end
    end
`else
    // Fixed-priority arbitration: data wins, fetch only when data is idle
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (resetn) begin
            w_grant_data = data_req;
            w_grant_inst = inst_req & ~data_req;
        end
    end
`endif

    assign w_grant_any  = w_grant_inst | w_grant_data;
    assign w_data_write = w_grant_data & data_wr;

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;

    // Drive the SRAM from whichever side holds the grant this cycle
    always_comb begin
        sram_en    = w_grant_any;
        sram_we    = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (w_grant_data) begin
            sram_addr = data_addr;
        end else if (w_grant_inst) begin
            sram_addr = inst_addr;
        end
        if (w_data_write) begin
            sram_we    = data_wstrb;
            sram_wdata = data_wdata;
        end
    end

    // Track the owner of the single in-flight response; cleared on idle cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_vld   <= 1'b0;
            r_resp_owner <= 1'b0;
        end else begin
            r_resp_vld   <= w_grant_any;
            r_resp_owner <= w_grant_data;
        end
    end

    assign inst_data_ok = r_resp_vld & ~r_resp_owner;
    assign data_data_ok = r_resp_vld & r_resp_owner;

    // Capture returned words so each port's rdata holds its last response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_hold <= 32'h0;
            r_data_hold <= 32'h0;
        end else begin
            if (inst_data_ok) begin
                r_inst_hold <= sram_rdata;
            end
            if (data_data_ok) begin
                r_data_hold <= sram_rdata;
            end
        end
    end

    assign inst_rdata = inst_data_ok ? sram_rdata : r_inst_hold;
    assign data_rdata = data_data_ok ? sram_rdata : r_data_hold;

endmodule
